// File: rtl/mac_sequencer_8bit.sv
// Streaming multiply-accumulate sequencer driving an external 8x8 shift/add multiplier.
// Define ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mac_sequencer_8bit #(
   parameter int ACC_W   = 20,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   input  logic             in_last,
   output logic             mul_start,
   output logic [7:0]       mul_a,
   output logic [7:0]       mul_b,
   input  logic [15:0]      mul_product,
   input  logic             mul_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             out_err
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int SUM_W = ACC_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             last_q;
   logic             ovf_q;
   logic             err_q;
   logic [TMO_W-1:0] tmo;
   logic [SUM_W-1:0] sum;
   logic [ACC_W-1:0] acc_nxt;

   assign sum = {1'b0, acc} + SUM_W'(mul_product);

   always_comb begin
      acc_nxt = sum[ACC_W-1:0];
`ifdef ACC_SATURATE_EN
      if (sum[ACC_W])
         acc_nxt = '1;
`endif
   end

   assign in_ready  = (state == IDLE);
   assign out_data  = acc;
   assign out_count = cnt;
   assign out_ovf   = ovf_q;
   assign out_err   = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         last_q    <= 1'b0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
         tmo       <= '0;
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         out_valid <= 1'b0;
      end else begin
         mul_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  mul_a     <= in_a;
                  mul_b     <= in_b;
                  last_q    <= in_last;
                  mul_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               tmo   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // a done arriving on the timeout cycle still counts
               if (mul_done) begin
                  acc <= acc_nxt;
                  cnt <= cnt + 1'b1;
                  if (sum[ACC_W])
                     ovf_q <= 1'b1;
                  if (last_q) begin
                     out_valid <= 1'b1;
                     state     <= OUT;
                  end else begin
                     state <= IDLE;
                  end
               end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                  err_q     <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  acc       <= '0;
                  cnt       <= '0;
                  ovf_q     <= 1'b0;
                  err_q     <= 1'b0;
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_sequencer_8bit.sv
// Scoreboard bench for mac_sequencer_8bit with a behavioural multiplier stub.
// Honours ACC_SATURATE_EN for the overflow expectation.
module tb_mac_sequencer_8bit;

   localparam int ACC_W   = 20;
   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 31;
   localparam int LAT     = 5;

   typedef struct {
      logic [ACC_W-1:0] d;
      logic [CNT_W-1:0] c;
      logic             ovf;
      logic             err;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
   } pair_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, in_last;
   logic [7:0]       in_a, in_b;
   logic             mul_start;
   logic [7:0]       mul_a, mul_b;
   logic [15:0]      mul_product;
   logic             mul_done;
   logic             out_valid, out_ready;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf, out_err;

   logic        model_done, spur, pend, stub, start_prev;
   logic [15:0] model_prod;
   int          lat_cnt;
   int          errors = 0;
   int          checks = 0;
   int          starts = 0;
   exp_t        exp_q[$];
   pair_t       iss_q[$];

   always #5 clk = ~clk;

   mac_sequencer_8bit #(.ACC_W(ACC_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_product(mul_product), .mul_done(mul_done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_count(out_count),
      .out_ovf(out_ovf), .out_err(out_err)
   );

   // multiplier stub: done pulse LAT cycles after start
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend       <= 1'b0;
         model_done <= 1'b0;
         model_prod <= '0;
         lat_cnt    <= 0;
      end else begin
         model_done <= 1'b0;
         if (mul_start && !stub) begin
            pend       <= 1'b1;
            lat_cnt    <= LAT - 1;
            model_prod <= 16'(mul_a) * 16'(mul_b);
         end else if (pend) begin
            if (lat_cnt == 0) begin
               pend       <= 1'b0;
               model_done <= 1'b1;
            end else begin
               lat_cnt <= lat_cnt - 1;
            end
         end
      end
   end

   assign mul_done    = model_done | spur;
   assign mul_product = model_prod;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // monitor: issue operands and results against the queues
   always @(negedge clk) begin
      if (rst) begin
         start_prev = 1'b0;
      end else begin
         if (mul_start) begin
            starts++;
            chk("start_width", 32'(start_prev), 0);
            if (iss_q.size() == 0) begin
               chk("unexpected_start", 1, 0);
            end else begin
               pair_t p;
               p = iss_q.pop_front();
               chk("mul_a", 32'(mul_a), 32'(p.a));
               chk("mul_b", 32'(mul_b), 32'(p.b));
            end
         end
         start_prev = mul_start;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_count", 32'(out_count), 32'(e.c));
               chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
               chk("out_err", 32'(out_err), 32'(e.err));
            end
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic last);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(in_ready), 1);
      in_a     = a;
      in_b     = b;
      in_last  = last;
      in_valid = 1'b1;
      @(posedge clk);
      iss_q.push_back('{a: a, b: b});
      #1 in_valid = 1'b0;
   endtask

   task automatic push_exp(input int d, input int c, input logic o,
                           input logic e);
      exp_q.push_back('{d: ACC_W'(d), c: CNT_W'(c), ovf: o, err: e});
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("result_seen", 32'(exp_q.size()), 0);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_valid", 32'(out_valid), 1);
   endtask

   initial begin
      int s0, n;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_last = 1'b0; out_ready = 1'b1; stub = 1'b0; spur = 1'b0;
      #1 chk("rst_in_ready", 32'(in_ready), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_mul_start", 32'(mul_start), 0);
      chk("rst_mul_a", 32'(mul_a), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_ovf_err", 32'({out_ovf, out_err}), 0);
      rst = 1'b0;

      // basic dot product
      s0 = starts;
      send(3, 4, 0);
      send(5, 6, 0);
      push_exp(98, 3, 0, 0);
      send(7, 8, 1);
      wait_done();
      chk("start_count", 32'(starts - s0), 3);

      // backpressure
      out_ready = 1'b0;
      push_exp(65025, 1, 0, 0);
      send(255, 255, 1);
      wait_valid();
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_data", 32'(out_data), 65025);
         chk("bp_in_ready", 32'(in_ready), 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 chk("bp_clear", 32'(out_valid), 0);
      wait_done();

      // accumulator overflow
`ifdef ACC_SATURATE_EN
      push_exp(1048575, 17, 1, 0);
`else
      push_exp(56849, 17, 1, 0);
`endif
      for (int i = 0; i < 17; i++)
         send(255, 255, (i == 16));
      wait_done();

      // pair counter wrap
      push_exp(257, 1, 0, 0);
      for (int i = 0; i < 257; i++)
         send(1, 1, (i == 256));
      wait_done();

      // multiplier timeout
      stub = 1'b1;
      push_exp(0, 0, 0, 1);
      send(9, 9, 1);
      @(negedge clk);
      chk("tmo_start", 32'(mul_start), 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      chk("tmo_latency", 32'(n == TIMEOUT || n == TIMEOUT + 1), 1);
      wait_done();
      stub = 1'b0;

      // reset in WAIT of pair 2
      send(3, 3, 0);
      send(4, 4, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_start", 32'(mul_start), 0);
      chk("mid_rst_ab", 32'({mul_a, mul_b}), 0);
      chk("mid_rst_data", 32'(out_data), 0);
      chk("mid_rst_count", 32'(out_count), 0);
      chk("mid_rst_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      push_exp(4, 1, 0, 0);
      send(2, 2, 1);
      wait_done();

      // spurious done in IDLE then in OUT
      @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      out_ready = 1'b0;
      push_exp(6, 1, 0, 0);
      send(2, 3, 1);
      wait_valid();
      @(posedge clk);
      #1 spur = 1'b1;
      @(posedge clk);
      #1 spur = 1'b0;
      @(negedge clk);
      chk("spur_out_data", 32'(out_data), 6);
      chk("spur_out_count", 32'(out_count), 1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_done();

      chk("issue_queue_empty", 32'(iss_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
